dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/dm_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: bus widths, FSM states
// and requester identifiers.
package dm_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that was not granted last wins. Grant is one-hot {B, A}.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_a && req_b) begin
      if (last_grant == REQ_B) grant[0] = 1'b1;
      else                     grant[1] = 1'b1;
    end else if (req_a) begin
      grant[0] = 1'b1;
    end else if (req_b) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates two requesters onto one registered-read data memory, one
// transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              a_rsp_ready,

  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  input  logic              b_rsp_ready,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state, state_n;
  req_id_t             owner, last_grant;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rsp_data;
  logic [1:0]          grant;
  logic                req_hs;
  logic                rsp_hs;

  rr_arb2 u_rr (
    .req_a      (a_req_valid),
    .req_b      (b_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Only the owner's rsp_ready can complete a response.
  assign rsp_hs = (owner == REQ_A) ? a_rsp_ready : b_rsp_ready;

  always_comb begin
    state_n     = state;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    req_hs      = 1'b0;
    case (state)
      S_IDLE: begin
        a_req_ready = grant[0];
        b_req_ready = grant[1];
        if (grant[0] || grant[1]) begin
          req_hs  = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  state_n = S_RESP;
      S_RESP:  if (rsp_hs) state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= REQ_A;
      last_grant <= REQ_B;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (req_hs) begin
      if (grant[1]) begin
        owner      <= REQ_B;
        last_grant <= REQ_B;
        lat_we     <= b_req_we;
        lat_addr   <= b_req_addr;
        lat_wdata  <= b_req_wdata;
      end else begin
        owner      <= REQ_A;
        last_grant <= REQ_A;
        lat_we     <= a_req_we;
        lat_addr   <= a_req_addr;
        lat_wdata  <= a_req_wdata;
      end
    end
  end

  // Memory read data is valid in WAIT, one cycle after the ISSUE address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rsp_data <= '0;
    else if (state == S_WAIT) rsp_data <= lat_we ? lat_wdata : mem_rdata;
  end

  assign mem_addr    = lat_addr;
  assign mem_wdata   = lat_wdata;
  assign mem_we      = (state == S_ISSUE) && lat_we;

  assign a_rsp_valid = (state == S_RESP) && (owner == REQ_A);
  assign b_rsp_valid = (state == S_RESP) && (owner == REQ_B);
  assign a_rsp_rdata = rsp_data;
  assign b_rsp_rdata = rsp_data;

endmodule
